dp_ram_be: RTL and testbench

- Parametrised single-clock dual-port RAM that succeeds the basic one-write/one-read dual-port memory used by the femtoriscv SoC.
- Port A reads or writes, with per-byte write enables. Port B is read-only and carries a read-valid flag.
- Memory depth follows the address width. Read-during-write collision behaviour is selectable, an output register stage is optional, and a built-in clear engine sweeps the array to a fixed value on request.
- Serves as program/data memory and as a frame/line buffer in the same SoC.

---
 rtl/dp_ram_be.sv | 196 +++++++++++++++++++
 tb/tb_dp_ram_be.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dp_ram_be.sv
// rtl/dp_ram_be.sv - single-clock dual-port RAM with byte enables, clear engine and optional parity (DP_RAM_BE_PARITY_EN)
module dp_ram_be #(
    parameter int                   ADR_WIDTH = 12,
    parameter int                   DAT_WIDTH = 32,
    parameter                       MEM_FILE  = "",
    parameter int                   RDW_MODE  = 0,
    parameter int                   OUT_REG   = 0,
    parameter logic [DAT_WIDTH-1:0] CLR_VALUE = '0
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   clr,
    output logic                   busy,
    output logic                   done,
    input  logic                   en_a,
    input  logic [DAT_WIDTH/8-1:0] we_a,
    input  logic [ADR_WIDTH-1:0]   adr_a,
    input  logic [DAT_WIDTH-1:0]   dat_a,
    output logic [DAT_WIDTH-1:0]   dat_a_out,
    output logic                   rvalid_a,
    input  logic                   en_b,
    input  logic                   re_b,
    input  logic [ADR_WIDTH-1:0]   adr_b,
    output logic [DAT_WIDTH-1:0]   dat_b,
    output logic                   rvalid_b
`ifdef DP_RAM_BE_PARITY_EN
    ,
    output logic [DAT_WIDTH/8-1:0] perr_a,
    output logic [DAT_WIDTH/8-1:0] perr_b
`endif
);

    localparam int DEPTH = 2 ** ADR_WIDTH;
    localparam int NB    = DAT_WIDTH / 8;
`ifdef DP_RAM_BE_PARITY_EN
    localparam int PB    = NB;
`else
    localparam int PB    = 0;
`endif
    // Stored word: data in the low bits, one parity bit per lane above it when enabled.
    localparam int SW    = DAT_WIDTH + PB;

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t               state, state_nx;
    logic [ADR_WIDTH-1:0] cnt, cnt_nx;
    logic [SW-1:0]        mem [DEPTH];

    logic                 wr_a, rd_a, rd_b;
    logic [SW-1:0]        wr_mask, wr_word, clr_word, b_word;
    logic [SW-1:0]        s1_a, s1_b, s_a, s_b;
    logic                 v1_a, v1_b, v_a, v_b;

    // Even parity of each byte lane.
    function automatic logic [NB-1:0] lane_par(input logic [DAT_WIDTH-1:0] d);
        logic [NB-1:0] p;
        for (int i = 0; i < NB; i++) p[i] = ^d[8*i +: 8];
        return p;
    endfunction

    // Build the stored word (data plus parity when enabled).
    function automatic logic [SW-1:0] enc(input logic [DAT_WIDTH-1:0] d);
`ifdef DP_RAM_BE_PARITY_EN
        return {lane_par(d), d};
`else
        return d;
`endif
    endfunction

    // Bit mask of stored bits owned by the enabled lanes, parity bit included.
    function automatic logic [SW-1:0] lane_mask(input logic [NB-1:0] we);
        logic [SW-1:0] m;
        m = '0;
        for (int i = 0; i < NB; i++) begin
            m[8*i +: 8] = {8{we[i]}};
`ifdef DP_RAM_BE_PARITY_EN
            m[DAT_WIDTH + i] = we[i];
`endif
        end
        return m;
    endfunction

    assign busy     = (state == CLEAR);
    assign done     = (state == DONE);
    assign wr_a     = resetn && en_a && (|we_a) && !busy;
    assign rd_a     = resetn && en_a && !(|we_a) && !busy;
    assign rd_b     = resetn && en_b && re_b && !busy;
    assign wr_mask  = lane_mask(we_a);
    assign wr_word  = enc(dat_a);
    assign clr_word = enc(CLR_VALUE);

    // Clear FSM state and sweep counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Clear FSM next state: one word per cycle, DONE for a single cycle after the last word.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (clr) begin
                    state_nx = CLEAR;
                    cnt_nx   = '0;
                end
            end
            CLEAR: begin
                if (cnt == {ADR_WIDTH{1'b1}}) begin
                    state_nx = DONE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Array write: the sweep owns the array while busy, otherwise port A merges its lanes.
    always_ff @(posedge clk) begin
        if (resetn) begin
            if (busy) begin
                mem[cnt] <= clr_word;
            end else if (wr_a) begin
                mem[adr_a] <= (mem[adr_a] & ~wr_mask) | (wr_word & wr_mask);
            end
        end
    end

    // Port B read word, with write-first bypass of the lanes port A is writing this cycle.
    always_comb begin
        b_word = mem[adr_b];
        if (RDW_MODE == 1 && wr_a && adr_a == adr_b) begin
            b_word = (mem[adr_b] & ~wr_mask) | (wr_word & wr_mask);
        end
    end

    // First read stage: capture on accepted reads, hold otherwise.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_a <= '0;
            s1_b <= '0;
            v1_a <= 1'b0;
            v1_b <= 1'b0;
        end else begin
            v1_a <= rd_a;
            v1_b <= rd_b;
            if (rd_a) s1_a <= mem[adr_a];
            if (rd_b) s1_b <= b_word;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            // Output stage: forward completed reads, hold data between them.
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    s_a <= '0;
                    s_b <= '0;
                    v_a <= 1'b0;
                    v_b <= 1'b0;
                end else begin
                    v_a <= v1_a;
                    v_b <= v1_b;
                    if (v1_a) s_a <= s1_a;
                    if (v1_b) s_b <= s1_b;
                end
            end
        end else begin : g_noreg
            assign s_a = s1_a;
            assign s_b = s1_b;
            assign v_a = v1_a;
            assign v_b = v1_b;
        end
    endgenerate

    assign dat_a_out = s_a[DAT_WIDTH-1:0];
    assign dat_b     = s_b[DAT_WIDTH-1:0];
    assign rvalid_a  = v_a;
    assign rvalid_b  = v_b;

`ifdef DP_RAM_BE_PARITY_EN
    // Parity check after the pipeline so the flags line up with rvalid.
    assign perr_a = s_a[SW-1 -: NB] ^ lane_par(s_a[DAT_WIDTH-1:0]);
    assign perr_b = s_b[SW-1 -: NB] ^ lane_par(s_b[DAT_WIDTH-1:0]);
`endif

endmodule

// File: tb/tb_dp_ram_be.sv
// tb/tb_dp_ram_be.sv - scoreboard bench for dp_ram_be in read-first/no-reg and write-first/out-reg builds
module tb_dp_ram_be;

    localparam logic [31:0] CLRV = 32'h5A5A5A5A;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  p;
        int          c;
    } exp_t;

    logic        clk, resetn, clr;
    logic        en_a, en_b, re_b;
    logic [3:0]  we_a;
    logic [5:0]  adr_a, adr_b;
    logic [31:0] dat_a;
    logic [31:0] dao [2];
    logic [31:0] dbo [2];
    logic [1:0]  rva, rvb, busy_o, done_o;
    logic [3:0]  pea [2];
    logic [3:0]  peb [2];

    exp_t qa [2][$];
    exp_t qb [2][$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    dp_ram_be #(.ADR_WIDTH(6), .DAT_WIDTH(32), .RDW_MODE(0), .OUT_REG(0), .CLR_VALUE(CLRV)) u0 (
        .clk(clk), .resetn(resetn), .clr(clr), .busy(busy_o[0]), .done(done_o[0]),
        .en_a(en_a), .we_a(we_a), .adr_a(adr_a), .dat_a(dat_a), .dat_a_out(dao[0]), .rvalid_a(rva[0]),
        .en_b(en_b), .re_b(re_b), .adr_b(adr_b), .dat_b(dbo[0]), .rvalid_b(rvb[0])
`ifdef DP_RAM_BE_PARITY_EN
        , .perr_a(pea[0]), .perr_b(peb[0])
`endif
    );

    dp_ram_be #(.ADR_WIDTH(6), .DAT_WIDTH(32), .RDW_MODE(1), .OUT_REG(1), .CLR_VALUE(CLRV)) u1 (
        .clk(clk), .resetn(resetn), .clr(clr), .busy(busy_o[1]), .done(done_o[1]),
        .en_a(en_a), .we_a(we_a), .adr_a(adr_a), .dat_a(dat_a), .dat_a_out(dao[1]), .rvalid_a(rva[1]),
        .en_b(en_b), .re_b(re_b), .adr_b(adr_b), .dat_b(dbo[1]), .rvalid_b(rvb[1])
`ifdef DP_RAM_BE_PARITY_EN
        , .perr_a(pea[1]), .perr_b(peb[1])
`endif
    );

`ifndef DP_RAM_BE_PARITY_EN
    assign pea[0] = 4'h0;
    assign pea[1] = 4'h0;
    assign peb[0] = 4'h0;
    assign peb[1] = 4'h0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the end of stimulus");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // Monitor: pop the oldest expectation for this DUT/port and compare data, perr and arrival cycle.
    task automatic mon(input int k, input bit port, input logic [31:0] d, input logic [3:0] p);
        exp_t e;
        n_cmp++;
        if ((port && qb[k].size() == 0) || (!port && qa[k].size() == 0)) begin
            n_err++;
            $display("FAIL rvalid_%s dut%0d: unexpected read data %h at cycle %0d, no read outstanding",
                     port ? "b" : "a", k, d, cyc);
        end else begin
            if (port) e = qb[k].pop_front();
            else      e = qa[k].pop_front();
            if (d !== e.d || cyc != e.c || p !== e.p) begin
                n_err++;
                $display("FAIL read_%s dut%0d: got data %h perr %b cycle %0d, required data %h perr %b cycle %0d",
                         port ? "b" : "a", k, d, p, cyc, e.d, e.p, e.c);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rva[k]) mon(k, 1'b0, dao[k], pea[k]);
            if (rvb[k]) mon(k, 1'b1, dbo[k], peb[k]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of port activity; read expectations go to the scoreboard with their due cycle.
    task automatic op(input bit ea, input logic [3:0] wea, input logic [5:0] aa, input logic [31:0] din,
                      input bit eb, input logic [5:0] ab,
                      input logic [31:0] xa0, input logic [31:0] xa1,
                      input logic [31:0] xb0, input logic [31:0] xb1, input logic [3:0] xp = 4'h0);
        if (ea && wea == 4'h0) begin
            qa[0].push_back('{xa0, xp, cyc + 1});
            qa[1].push_back('{xa1, xp, cyc + 2});
        end
        if (eb) begin
            qb[0].push_back('{xb0, 4'h0, cyc + 1});
            qb[1].push_back('{xb1, 4'h0, cyc + 2});
        end
        en_a = ea; we_a = wea; adr_a = aa; dat_a = din;
        en_b = eb; re_b = eb; adr_b = ab;
        tick();
        en_a = 1'b0; we_a = 4'h0; en_b = 1'b0; re_b = 1'b0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] we);
        op(1'b1, we, a, d, 1'b0, 6'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic rda(input logic [5:0] a, input logic [31:0] x, input logic [3:0] xp = 4'h0);
        op(1'b1, 4'h0, a, 32'h0, 1'b0, 6'h0, x, x, 32'h0, 32'h0, xp);
    endtask

    task automatic rdb(input logic [5:0] a, input logic [31:0] x);
        op(1'b0, 4'h0, 6'h0, 32'h0, 1'b1, a, 32'h0, 32'h0, x, x);
    endtask

    int nb0, nb1, nd0, nd1, fb, fd;

    initial begin
        resetn = 1'b0; clr = 1'b0;
        en_a = 1'b0; we_a = 4'h0; adr_a = 6'h0; dat_a = 32'h0;
        en_b = 1'b0; re_b = 1'b0; adr_b = 6'h0;
        repeat (2) tick();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset_outputs dut%0d", k),
                {dao[k], dbo[k][27:0], rva[k], rvb[k], busy_o[k], done_o[k]}, 64'h0);
        end
        resetn = 1'b1;
        tick();

        // First write and read, then byte-lane merge observed on both ports.
        wr(6'h00, 32'h12345678, 4'hF);
        rda(6'h00, 32'h12345678);
        wr(6'h10, 32'hAABBCCDD, 4'hF);
        wr(6'h10, 32'h11223344, 4'b0101);
        rdb(6'h10, 32'hAA22CC44);
        rda(6'h10, 32'hAA22CC44);

        // Collision: u0 read-first, u1 write-first.
        wr(6'h20, 32'h00000000, 4'hF);
        op(1'b1, 4'b0011, 6'h20, 32'hFFFFFFFF, 1'b1, 6'h20, 32'h0, 32'h0, 32'h00000000, 32'h0000FFFF);
        rdb(6'h20, 32'h0000FFFF);

        // Back-to-back reads on both ports.
        op(1'b1, 4'h0, 6'h00, 32'h0, 1'b1, 6'h10, 32'h12345678, 32'h12345678, 32'hAA22CC44, 32'hAA22CC44);
        op(1'b1, 4'h0, 6'h10, 32'h0, 1'b1, 6'h20, 32'hAA22CC44, 32'hAA22CC44, 32'h0000FFFF, 32'h0000FFFF);
        op(1'b1, 4'h0, 6'h20, 32'h0, 1'b1, 6'h00, 32'h0000FFFF, 32'h0000FFFF, 32'h12345678, 32'h12345678);

        // Full sweep; a read issued with clr is still accepted.
        clr = 1'b1;
        rda(6'h10, 32'hAA22CC44);
        clr = 1'b0;
        nb0 = 0; nb1 = 0; nd0 = 0; nd1 = 0; fb = -1; fd = -1;
        for (int i = 0; i < 80; i++) begin
            if (busy_o[0]) nb0++;
            if (busy_o[1]) nb1++;
            if (done_o[0]) begin nd0++; fd = i; end
            if (done_o[1]) nd1++;
            if (busy_o[0] && fb < 0) fb = i;
            if (i == 10) begin
                en_a = 1'b1; we_a = 4'hF; adr_a = 6'h10; dat_a = 32'h0;
                en_b = 1'b1; re_b = 1'b1; adr_b = 6'h10;
            end
            if (i == 11) begin
                en_a = 1'b1; we_a = 4'h0; adr_a = 6'h11; clr = 1'b1;
            end
            tick();
            en_a = 1'b0; we_a = 4'h0; en_b = 1'b0; re_b = 1'b0; clr = 1'b0;
        end
        chk("sweep_busy_cycles dut0", 64'(nb0), 64'd64);
        chk("sweep_busy_cycles dut1", 64'(nb1), 64'd64);
        chk("sweep_done_pulses dut0", 64'(nd0), 64'd1);
        chk("sweep_done_pulses dut1", 64'(nd1), 64'd1);
        chk("sweep_busy_start", 64'(fb), 64'd0);
        chk("sweep_done_cycle", 64'(fd), 64'd64);
        for (int a = 0; a < 64; a++) begin
            op(1'b1, 4'h0, 6'(a), 32'h0, 1'b1, 6'(63 - a), CLRV, CLRV, CLRV, CLRV);
        end

        // Reset during sweep cycle 5.
        for (int i = 0; i < 10; i++) wr(6'(i), 32'hC0DE0000 | i, 4'hF);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (5) tick();
        resetn = 1'b0;
        tick();
        chk("abort_busy", {62'h0, busy_o}, 64'h0);
        chk("abort_done", {62'h0, done_o}, 64'h0);
        resetn = 1'b1;
        nd0 = 0; nb0 = 0;
        for (int i = 0; i < 70; i++) begin
            if (done_o != 2'b00) nd0++;
            if (busy_o != 2'b00) nb0++;
            tick();
        end
        chk("abort_no_done", 64'(nd0), 64'd0);
        chk("abort_no_busy", 64'(nb0), 64'd0);
        for (int i = 0; i < 10; i++) rda(6'(i), (i < 5) ? CLRV : (32'hC0DE0000 | i));

`ifdef DP_RAM_BE_PARITY_EN
        // Corrupt one data bit in lane 2 behind the parity bit's back.
        wr(6'h30, 32'h01020304, 4'hF);
        u0.mem[6'h30][17] = ~u0.mem[6'h30][17];
        u1.mem[6'h30][17] = ~u1.mem[6'h30][17];
        rda(6'h30, 32'h01000304, 4'b0100);
        rda(6'h20, CLRV, 4'b0000);
`endif

        repeat (5) tick();
        chk("scoreboard_drained", 64'(qa[0].size() + qa[1].size() + qb[0].size() + qb[1].size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
